// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl
// Sensor-actuated controller for an N-approach intersection. One approach at a
// time owns the green phase. The owner is chosen round-robin among the
// approaches that report a vehicle. Every green is followed by yellow and then
// by an all-red clearance. A flash (night) mode blinks every head red/off.
// All outputs are registered. The lamp pattern is decoded from the next state,
// so the lamps change on the same edge as the state.

module traffic_intersection_ctrl #(
    parameter int NUM_DIR     = 4,
    parameter int TIMER_W     = 16,
    parameter int MIN_GREEN   = 10,
    parameter int MAX_GREEN   = 50,
    parameter int YELLOW_TIME = 5,
    parameter int ALLRED_TIME = 2,
    parameter int FLASH_HALF  = 25,
    localparam int DIR_W      = $clog2(NUM_DIR)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_DIR-1:0]     sensor,
    input  logic                   flash_req,
    output logic [2*NUM_DIR-1:0]   light,
    output logic [DIR_W-1:0]       active_dir,
    output logic                   phase_go
);

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_FLASH   = 2'd3
    } state_t;

    localparam logic [1:0] LAMP_OFF    = 2'b00;
    localparam logic [1:0] LAMP_RED    = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;
    localparam logic [1:0] LAMP_GREEN  = 2'b11;

    // Phase timers hold (length - 1) and count down to zero.
    localparam logic [TIMER_W-1:0] ALLRED_LOAD = TIMER_W'(ALLRED_TIME - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LOAD = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] FLASH_LOAD  = TIMER_W'(FLASH_HALF - 1);
    localparam logic [TIMER_W-1:0] MIN_G       = TIMER_W'(MIN_GREEN);
    localparam logic [TIMER_W-1:0] MAX_G       = TIMER_W'(MAX_GREEN);
    localparam logic [TIMER_W-1:0] TIMER_ZERO  = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_SAT   = {TIMER_W{1'b1}};

    // Round-robin pick: first requesting approach after cur, wrapping.
    // The last candidate examined is cur itself; with no request at all the
    // grant stays on cur so the intersection rests in green there.
    function automatic logic [DIR_W-1:0] rr_pick(
        input logic [DIR_W-1:0]   cur,
        input logic [NUM_DIR-1:0] req
    );
        logic [DIR_W-1:0] pick;
        logic [DIR_W:0]   sum;
        logic             found;
        pick  = cur;
        found = 1'b0;
        for (int i = 1; i <= NUM_DIR; i++) begin
            sum = {1'b0, cur} + (DIR_W+1)'(i);
            if (sum >= (DIR_W+1)'(NUM_DIR)) begin
                sum = sum - (DIR_W+1)'(NUM_DIR);
            end else begin
                sum = sum;
            end
            if (!found && req[sum[DIR_W-1:0]]) begin
                pick  = sum[DIR_W-1:0];
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Lamp pattern for a given state, owning approach and flash half.
    function automatic logic [2*NUM_DIR-1:0] decode_light(
        input state_t           st,
        input logic [DIR_W-1:0] dir,
        input logic             flash_on
    );
        logic [2*NUM_DIR-1:0] l;
        l = {(2*NUM_DIR){1'b0}};
        for (int i = 0; i < NUM_DIR; i++) begin
            case (st)
                ST_FLASH:  l[2*i +: 2] = flash_on ? LAMP_RED : LAMP_OFF;
                ST_GREEN:  l[2*i +: 2] = (DIR_W'(i) == dir) ? LAMP_GREEN : LAMP_RED;
                ST_YELLOW: l[2*i +: 2] = (DIR_W'(i) == dir) ? LAMP_YELLOW : LAMP_RED;
                ST_ALL_RED: l[2*i +: 2] = LAMP_RED;
                default:   l[2*i +: 2] = LAMP_RED;
            endcase
        end
        return l;
    endfunction

    state_t               state_r;
    logic [TIMER_W-1:0]   timer_r;
    logic [TIMER_W-1:0]   elapsed_r;
    logic [DIR_W-1:0]     active_dir_r;
    logic                 flash_on_r;
    logic [2*NUM_DIR-1:0] light_r;
    logic                 phase_go_r;

    state_t               nxt_state_s;
    logic [TIMER_W-1:0]   nxt_timer_s;
    logic [TIMER_W-1:0]   nxt_elapsed_s;
    logic [DIR_W-1:0]     nxt_dir_s;
    logic                 nxt_flash_on_s;
    logic [NUM_DIR-1:0]   owner_mask_s;
    logic                 other_req_s;
    logic                 green_exit_s;

    // Request view and green-exit decision for the current owner.
    always_comb begin
        owner_mask_s = {{(NUM_DIR-1){1'b0}}, 1'b1} << active_dir_r;
        other_req_s  = |(sensor & ~owner_mask_s);
        green_exit_s = (elapsed_r >= MIN_G) &&
                       (flash_req ||
                        (other_req_s && (!sensor[active_dir_r] || (elapsed_r >= MAX_G))));
    end

    // Next-state, timer, elapsed and grant computation.
    always_comb begin
        nxt_state_s    = state_r;
        nxt_timer_s    = timer_r;
        nxt_elapsed_s  = elapsed_r;
        nxt_dir_s      = active_dir_r;
        nxt_flash_on_s = flash_on_r;
        case (state_r)
            ST_ALL_RED: begin
                if (timer_r == TIMER_ZERO) begin
                    if (flash_req) begin
                        nxt_state_s    = ST_FLASH;
                        nxt_timer_s    = FLASH_LOAD;
                        nxt_flash_on_s = 1'b1;
                    end else begin
                        nxt_state_s   = ST_GREEN;
                        nxt_dir_s     = rr_pick(active_dir_r, sensor);
                        nxt_elapsed_s = TIMER_ONE;
                        nxt_timer_s   = TIMER_ZERO;
                    end
                end else begin
                    nxt_timer_s = timer_r - TIMER_ONE;
                end
            end
            ST_GREEN: begin
                if (green_exit_s) begin
                    nxt_state_s = ST_YELLOW;
                    nxt_timer_s = YELLOW_LOAD;
                end else if (elapsed_r != TIMER_SAT) begin
                    nxt_elapsed_s = elapsed_r + TIMER_ONE;
                end else begin
                    nxt_elapsed_s = elapsed_r;
                end
            end
            ST_YELLOW: begin
                if (timer_r == TIMER_ZERO) begin
                    nxt_state_s = ST_ALL_RED;
                    nxt_timer_s = ALLRED_LOAD;
                end else begin
                    nxt_timer_s = timer_r - TIMER_ONE;
                end
            end
            ST_FLASH: begin
                if (timer_r == TIMER_ZERO) begin
                    if (!flash_req) begin
                        nxt_state_s    = ST_ALL_RED;
                        nxt_timer_s    = ALLRED_LOAD;
                        nxt_flash_on_s = 1'b0;
                    end else begin
                        nxt_flash_on_s = ~flash_on_r;
                        nxt_timer_s    = FLASH_LOAD;
                    end
                end else begin
                    nxt_timer_s = timer_r - TIMER_ONE;
                end
            end
            default: begin
                nxt_state_s    = ST_ALL_RED;
                nxt_timer_s    = ALLRED_LOAD;
                nxt_flash_on_s = 1'b0;
            end
        endcase
    end

    // State register with registered lamp decode and green-start pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_ALL_RED;
            timer_r      <= ALLRED_LOAD;
            elapsed_r    <= TIMER_ZERO;
            active_dir_r <= {DIR_W{1'b0}};
            flash_on_r   <= 1'b0;
            light_r      <= decode_light(ST_ALL_RED, {DIR_W{1'b0}}, 1'b0);
            phase_go_r   <= 1'b0;
        end else begin
            state_r      <= nxt_state_s;
            timer_r      <= nxt_timer_s;
            elapsed_r    <= nxt_elapsed_s;
            active_dir_r <= nxt_dir_s;
            flash_on_r   <= nxt_flash_on_s;
            light_r      <= decode_light(nxt_state_s, nxt_dir_s, nxt_flash_on_s);
            phase_go_r   <= (nxt_state_s == ST_GREEN) && (state_r != ST_GREEN);
        end
    end

    assign light      = light_r;
    assign active_dir = active_dir_r;
    assign phase_go   = phase_go_r;

endmodule
